// File: rtl/fixed_divider_pkg.sv
// Shared constants and FSM encoding for the neuron fixed-point datapath.
// Q12.20 sign-magnitude defaults; the divider derives its widths from these.
package neuron_pkg;
    localparam int N        = 32;
    localparam int INTBITS  = 12;
    localparam int FRACBITS = 20;
    localparam int DIV_W    = N - 1 + FRACBITS;
    localparam int DIV_CW   = $clog2(DIV_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;
endpackage

// File: rtl/fixed_divider_if.sv
// Start/done handshake bundle between the neuron control logic and the divider.
interface fixed_divider_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         ovf;
    logic         dz;

    modport master (
        output start, a, b,
        input  busy, done, result, ovf, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, ovf, dz
    );
endinterface

// File: rtl/fixed_divider_div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, subtract if it fits.
module div_step #(
    parameter int n = 32
) (
    input  logic [n-1:0] rem,
    input  logic         bit_in,
    input  logic [n-2:0] b_mag,
    output logic [n-1:0] rem_next,
    output logic         q_bit
);
    logic [n-1:0] shifted;
    logic [n-1:0] divisor;

    always_comb begin
        shifted  = {rem[n-2:0], bit_in};
        divisor  = {1'b0, b_mag};
        q_bit    = (shifted >= divisor);
        rem_next = q_bit ? (shifted - divisor) : shifted;
    end
endmodule

// File: rtl/fixed_divider.sv
// Sequential sign-magnitude fixed-point divider, one quotient bit per clock.
// Shares the Q-format of the combinational multiplier; start/done handshake.
module fixed_divider
    import neuron_pkg::*;
#(
    parameter int n        = N,
    parameter int intbits  = INTBITS,
    parameter int fracbits = FRACBITS
) (
    input  logic            clk,
    input  logic            rst,
    fixed_divider_if.slave  bus
);
    localparam int W  = n - 1 + fracbits;
    localparam int CW = $clog2(W + 1);

    if (intbits + fracbits != n) begin : g_bad_format
        $error("fixed_divider: intbits + fracbits must equal n");
    end

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  dvd;
    logic [W-1:0]  quo;
    logic [n-1:0]  rem;
    logic [n-2:0]  b_mag;
    logic          sign;
    logic          by_zero;

    logic [n-1:0]  rem_next;
    logic          q_bit;
    logic [W-1:0]  quo_next;

    div_step #(.n(n)) u_step (
        .rem      (rem),
        .bit_in   (dvd[W-1]),
        .b_mag    (b_mag),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign quo_next = {quo[W-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dvd        <= '0;
            quo        <= '0;
            rem        <= '0;
            b_mag      <= '0;
            sign       <= 1'b0;
            by_zero    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.ovf    <= 1'b0;
            bus.dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sign     <= bus.a[n-1] ^ bus.b[n-1];
                        b_mag    <= bus.b[n-2:0];
                        dvd      <= {bus.a[n-2:0], {fracbits{1'b0}}};
                        quo      <= '0;
                        rem      <= '0;
                        bus.busy <= 1'b1;
                        state    <= CALC;
                        // A zero divisor spends a single CALC cycle so its result lands one edge later.
                        by_zero  <= (bus.b[n-2:0] == '0);
                        cnt      <= (bus.b[n-2:0] == '0) ? CW'(1) : CW'(W);
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    dvd <= {dvd[W-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        if (by_zero) begin
                            bus.result <= {sign, {(n-1){1'b1}}};
                            bus.ovf    <= 1'b1;
                            bus.dz     <= 1'b1;
                        end else begin
                            bus.result <= {sign, quo_next[n-2:0]};
                            bus.ovf    <= |quo_next[W-1:n-1];
                            bus.dz     <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench: timeline/arithmetic reference model, directed cases and random traffic.
module tb_fixed_divider;
    localparam int W = 51;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fixed_divider_if #(.N(32)) bus ();

    fixed_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    // Reference model: an accepted op completes at a known edge with an arithmetically computed result.
    bit          m_busy = 1'b0;
    int          m_end  = -10;
    logic [31:0] m_res  = '0;
    logic        m_ovf  = 1'b0;
    logic        m_dz   = 1'b0;
    logic [31:0] p_res;
    logic        p_ovf;
    logic        p_dz;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic o, output logic d);
        logic [30:0] am;
        logic [30:0] bm;
        logic        s;
        logic [63:0] num;
        logic [63:0] q;
        am = a[30:0];
        bm = b[30:0];
        s  = a[31] ^ b[31];
        if (bm == '0) begin
            r = {s, 31'h7FFF_FFFF};
            o = 1'b1;
            d = 1'b1;
        end else begin
            num = {33'b0, am} << 20;
            q   = num / {33'b0, bm};
            r   = {s, q[30:0]};
            o   = (q >> 31) != 64'd0;
            d   = 1'b0;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_end  = -10;
            m_res  = '0;
            m_ovf  = 1'b0;
            m_dz   = 1'b0;
        end else if (m_busy) begin
            if (cyc == m_end) begin
                m_res = p_res;
                m_ovf = p_ovf;
                m_dz  = p_dz;
            end else if (cyc == m_end + 1) begin
                m_busy = 1'b0;
            end
        end else if (bus.start) begin
            model_div(bus.a, bus.b, p_res, p_ovf, p_dz);
            m_end  = cyc + (p_dz ? 1 : W);
            m_busy = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_busy && cyc == m_end));
            check("result", bus.result, m_res);
            check("ovf", 32'(bus.ovf), 32'(m_ovf));
            check("dz", 32'(bus.dz), 32'(m_dz));
            if (bus.done) n_done++;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200 && bus.busy; i++) begin
            @(posedge clk);
            #1;
        end
        if (bus.busy) check("idle timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_dir(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input logic exp_o, input logic exp_d,
                           input int exp_lat, input bit intrude);
        int lat;
        bit seen;
        wait_idle();
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 120 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = intrude && (lat == 20);
            if (bus.done) seen = 1'b1;
        end
        bus.start = 1'b0;
        if (!seen) begin
            check({name, " done timeout"}, 32'(seen), 32'd1);
        end else begin
            check({name, " latency"}, 32'(lat), 32'(exp_lat));
            check({name, " result"}, bus.result, exp_r);
            check({name, " ovf"}, 32'(bus.ovf), 32'(exp_o));
            check({name, " dz"}, 32'(bus.dz), 32'(exp_d));
            check({name, " model result"}, m_res, exp_r);
        end
    endtask

    initial begin
        bit          saw_done;
        int          sel;
        logic        s;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset ovf", 32'(bus.ovf), 32'd0);
        check("reset dz", 32'(bus.dz), 32'd0);
        rst = 1'b0;

        run_dir("6/2", 32'h0060_0000, 32'h0020_0000, 32'h0030_0000, 1'b0, 1'b0, W, 1'b0);
        run_dir("-1/4", 32'h8010_0000, 32'h0040_0000, 32'h8004_0000, 1'b0, 1'b0, W, 1'b0);
        run_dir("1/3 start ignored", 32'h0010_0000, 32'h0030_0000, 32'h0005_5555, 1'b0, 1'b0, W, 1'b1);
        run_dir("overflow", 32'h7FF0_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, W, 1'b0);
        run_dir("div -0", 32'h0010_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, 1'b0);

        // Reset ten cycles into a divide: everything clears and the op never completes.
        wait_idle();
        bus.a     = 32'h0060_0000;
        bus.b     = 32'h0020_0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid reset busy", 32'(bus.busy), 32'd0);
        check("mid reset done", 32'(bus.done), 32'd0);
        check("mid reset result", bus.result, 32'd0);
        check("mid reset ovf", 32'(bus.ovf), 32'd0);
        check("mid reset dz", 32'(bus.dz), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        check("no done after reset", 32'(saw_done), 32'd0);
        run_dir("6/2 after reset", 32'h0060_0000, 32'h0020_0000, 32'h0030_0000, 1'b0, 1'b0, W, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst       = ($urandom_range(0, 499) == 0);
            bus.start = ($urandom_range(0, 3) != 0);
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            case (sel)
                0:       bus.b = {s, 31'b0};
                1:       bus.b = {s, 31'($urandom_range(1, 15))};
                2:       bus.b = {s, 11'b0, 20'($urandom)};
                default: bus.b = $urandom;
            endcase
            bus.a = ($urandom_range(0, 3) == 0) ? {1'($urandom_range(0, 1)), 11'b0, 20'($urandom)} : $urandom;
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        check("ops completed", 32'(n_done >= 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
